dm_ctrl: RTL and testbench

DM_CTRL -- requirements
Module: dm_ctrl

---
 rtl/dm_ctrl.sv | 159 +++++++++++++++
 tb/tb_dm_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - M-stage data-memory access controller (IDLE/WAIT/DONE), optional DM_CTRL_TIMEOUT_EN bus timeout
module dm_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  DMOp,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rd_out,
  output logic [31:0] addr_out,
  output logic [3:0]  DMOp_out,
  output logic        rd_valid,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q;
  logic        mem_req_q, mem_we_q, rd_valid_q;
  logic [31:0] mem_addr_q, mem_wdata_q, rd_out_q, addr_out_q;
  logic [3:0]  mem_byteen_q, dmop_q;

  logic        op_load, op_store, aligned, in_idle, accept;
  logic [3:0]  byteen_d;
  logic [31:0] wdata_d;

  // Decode the op: load/store class, alignment rule, lane enables and replicated store data
  always_comb begin
    op_load  = 1'b0;
    op_store = 1'b0;
    aligned  = 1'b1;
    byteen_d = 4'b0000;
    wdata_d  = wdata;
    case (DMOp)
      4'b1000: begin op_load = 1'b1; aligned = (addr[1:0] == 2'b00); end
      4'b1001: begin op_load = 1'b1; aligned = ~addr[0]; end
      4'b1010: begin op_load = 1'b1; end
      4'b0100: begin
        op_store = 1'b1;
        aligned  = (addr[1:0] == 2'b00);
        byteen_d = 4'b1111;
      end
      4'b0101: begin
        op_store = 1'b1;
        aligned  = ~addr[0];
        byteen_d = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d  = {2{wdata[15:0]}};
      end
      4'b0110: begin
        op_store = 1'b1;
        byteen_d = 4'b0001 << addr[1:0];
        wdata_d  = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign in_idle  = (state_q == S_IDLE);
  assign accept   = in_idle & req_valid & (op_load | op_store) & aligned;
  assign exc_adel = in_idle & req_valid & op_load & ~aligned;
  assign exc_ades = in_idle & req_valid & op_store & ~aligned;
  assign stall    = accept | (state_q == S_WAIT);

`ifdef DM_CTRL_TIMEOUT_EN
  logic [3:0] cnt_q;
  logic       bus_err_q;
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Access sequencer: latch on accept, hold request until ack (or timeout), one DONE cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_byteen_q <= 4'b0000;
      rd_out_q     <= 32'd0;
      addr_out_q   <= 32'd0;
      dmop_q       <= 4'b0000;
`ifdef DM_CTRL_TIMEOUT_EN
      cnt_q        <= 4'd0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          rd_valid_q <= 1'b0;
          if (accept) begin
            addr_out_q   <= addr;
            dmop_q       <= DMOp;
            mem_addr_q   <= {addr[31:2], 2'b00};
            mem_byteen_q <= byteen_d;
            mem_wdata_q  <= wdata_d;
            mem_req_q    <= 1'b1;
            mem_we_q     <= op_store;
`ifdef DM_CTRL_TIMEOUT_EN
            cnt_q        <= 4'd0;
`endif
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            rd_valid_q <= dmop_q[3];
            if (dmop_q[3]) rd_out_q <= mem_rdata;
            state_q    <= S_DONE;
          end
`ifdef DM_CTRL_TIMEOUT_EN
          else if (cnt_q == 4'hF) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            bus_err_q <= 1'b1;
            rd_out_q  <= 32'd0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
`endif
        end
        S_DONE: begin
          rd_valid_q <= 1'b0;
`ifdef DM_CTRL_TIMEOUT_EN
          bus_err_q  <= 1'b0;
`endif
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_byteen = mem_byteen_q;
  assign mem_wdata  = mem_wdata_q;
  assign rd_out     = rd_out_q;
  assign addr_out   = addr_out_q;
  assign DMOp_out   = dmop_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - scoreboard bench for dm_ctrl with randomized ops and a reference model
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  DMOp = 4'b0000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, rd_out, addr_out;
  logic [3:0]  mem_byteen, DMOp_out;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        rd_valid, exc_adel, exc_ades, bus_err;

  int errors = 0;
  int checks = 0;
  bit resp_off = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          dly;
    logic [31:0] rdata;
  } acc_t;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] addr;
    logic [3:0]  op;
  } ld_t;

  acc_t acc_q[$];
  ld_t  ld_q[$];

  dm_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .DMOp(DMOp), .addr(addr), .wdata(wdata),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rd_out(rd_out), .addr_out(addr_out), .DMOp_out(DMOp_out), .rd_valid(rd_valid),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // kind: 0 = no access, 1 = load, 2 = store; size in bytes
  task automatic op_info(input logic [3:0] op, output int kind, output int size);
    kind = 0;
    size = 1;
    case (op)
      4'b1000: begin kind = 1; size = 4; end
      4'b1001: begin kind = 1; size = 2; end
      4'b1010: begin kind = 1; size = 1; end
      4'b0100: begin kind = 2; size = 4; end
      4'b0101: begin kind = 2; size = 2; end
      4'b0110: begin kind = 2; size = 1; end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] rdat, input bit rv);
    int kind, size, n;
    bit acc, mis;
    logic [63:0] lane, rep;
    acc_t e;
    ld_t l;
    op_info(op, kind, size);
    mis = (kind != 0) && ((a % size) != 0);
    acc = rv && (kind != 0) && !mis;
    @(posedge clk); #1;
    req_valid = rv; DMOp = op; addr = a; wdata = wd;
    if (acc) begin
      lane = 64'(wd) & ((64'd1 << (8 * size)) - 64'd1);
      rep = 64'd0;
      for (int i = 0; i < 4 / size; i++) rep = rep | (lane << (8 * size * i));
      e.we    = (kind == 2);
      e.addr  = a - (a % 4);
      e.be    = (kind == 2) ? 4'(((1 << size) - 1) << (a % 4)) : 4'b0000;
      e.wd    = (kind == 2) ? rep[31:0] : 32'd0;
      e.dly   = dly;
      e.rdata = rdat;
      acc_q.push_back(e);
      if (kind == 1) begin
        l.rd = rdat; l.addr = a; l.op = op;
        ld_q.push_back(l);
      end
    end
    @(negedge clk);
    chk("exc_adel", exc_adel, rv && kind == 1 && mis);
    chk("exc_ades", exc_ades, rv && kind == 2 && mis);
    chk("stall_first", stall, acc);
    if (acc) begin
      n = 1;
      while (n < 100) begin
        @(negedge clk);
        if (!stall) break;
        n++;
      end
      chk("stall_cycles", n, 2 + dly);
      chk("addr_out", addr_out, a);
      chk("DMOp_out", DMOp_out, op);
    end
  endtask

  // Memory responder: checks each new access against the scoreboard and acks after the queued delay
  initial begin
    acc_t a;
    forever begin
      @(negedge clk);
      if (mem_req && !resp_off) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_access", mem_req, 1'b0);
          @(posedge clk);
        end else begin
          a = acc_q.pop_front();
          chk("mem_we", mem_we, a.we);
          chk("mem_addr", mem_addr, a.addr);
          chk("mem_byteen", mem_byteen, a.be);
          if (a.we) chk("mem_wdata", mem_wdata, a.wd);
          repeat (a.dly) @(negedge clk);
          chk("mem_req_held", mem_req, 1'b1);
          chk("mem_addr_held", mem_addr, a.addr);
          mem_ack = 1'b1;
          mem_rdata = a.rdata;
          @(posedge clk); #1;
          mem_ack = 1'b0;
          mem_rdata = 32'h0BAD_F00D;
        end
      end
    end
  end

  // Load-result monitor
  initial begin
    ld_t l;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (ld_q.size() == 0) chk("unexpected_rd_valid", rd_valid, 1'b0);
        else begin
          l = ld_q.pop_front();
          chk("rd_out", rd_out, l.rd);
          chk("rd_addr_out", addr_out, l.addr);
          chk("rd_DMOp_out", DMOp_out, l.op);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [10];
    int n;
    ops = '{4'b0000, 4'b1000, 4'b1001, 4'b1010, 4'b0100, 4'b0101, 4'b0110, 4'b0011, 4'b1111, 4'b1100};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_out", rd_out, 32'd0);
    chk("rst_addr_out", addr_out, 32'd0);
    chk("rst_DMOp_out", DMOp_out, 4'b0000);
    chk("rst_byteen", mem_byteen, 4'b0000);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // directed: lw with ack in the second WAIT cycle, sb lane 3, misaligned lh
    issue(4'b1000, 32'h0000_1004, 32'h0, 1, 32'hDEAD_BEEF, 1'b1);
    issue(4'b0110, 32'h0000_2003, 32'h0000_00A5, 0, 32'h0, 1'b1);
    issue(4'b1001, 32'h0000_3001, 32'h0, 0, 32'h0, 1'b1);
    chk("lh_mis_mem_req", mem_req, 1'b0);

    // randomized mix including illegal ops, misalignment and idle cycles
    for (int i = 0; i < 80; i++) begin
      issue(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom_range(0, 3),
            $urandom, $urandom_range(0, 7) != 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;

    // reset in the middle of a lw WAIT, then a stray ack
    repeat (3) @(posedge clk);
    resp_off = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; DMOp = 4'b1000; addr = 32'h0000_1004;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_mem_req", mem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_mem_req", mem_req, 1'b0);
    chk("post_rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_mem_req", mem_req, 1'b0);
    chk("stray_ack_rd_out", rd_out, 32'd0);
    chk("stray_ack_rd_valid", rd_valid, 1'b0);

    // sw with no ack
    @(posedge clk); #1;
    req_valid = 1'b1; DMOp = 4'b0100; addr = 32'h0000_0040; wdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("to_stall_first", stall, 1'b1);
`ifdef DM_CTRL_TIMEOUT_EN
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk("to_stall_cycles", n, 17);
    chk("to_bus_err", bus_err, 1'b1);
    chk("to_mem_req", mem_req, 1'b0);
    chk("to_rd_valid", rd_valid, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("to_bus_err_pulse", bus_err, 1'b0);
`else
    repeat (30) @(negedge clk);
    chk("noto_stall", stall, 1'b1);
    chk("noto_mem_req", mem_req, 1'b1);
    chk("noto_mem_we", mem_we, 1'b1);
    chk("noto_bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("noto_release", stall, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
`endif
    resp_off = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("acc_q_empty", acc_q.size(), 0);
    chk("ld_q_empty", ld_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
